// File: rtl/parking_gate_occupancy_if.sv
// Gate-side bus of the parking lot occupancy tracker: gate requests and sensor in,
// occupancy status, gate control and event pulses out.
interface parking_gate_occupancy_if #(
    parameter int CNT_W = 4
);
    // Handshake: entry_req/exit_req are levels held by the requester. They are accepted
    // only while the gate is closed. gate_open (with gate_dir) acknowledges acceptance.
    // car_passed is a one-cycle sensor pulse that completes the passage and is ignored
    // while the gate is closed. Exactly one of done/timeout pulses when the gate closes.
    // entry_denied/exit_denied pulse instead of gate_open when the lot cannot serve the request.
    logic             entry_req;
    logic             exit_req;
    logic             car_passed;
    logic [CNT_W-1:0] parked;
    logic [CNT_W-1:0] empty;
    logic             full;
    logic             vacant;
    logic             gate_open;
    logic             gate_dir;
    logic             done;
    logic             timeout;
    logic             entry_denied;
    logic             exit_denied;
    logic [1:0]       fsm_state;

    modport master (
        output entry_req, exit_req, car_passed,
        input  parked, empty, full, vacant, gate_open, gate_dir,
        input  done, timeout, entry_denied, exit_denied, fsm_state
    );

    modport slave (
        input  entry_req, exit_req, car_passed,
        output parked, empty, full, vacant, gate_open, gate_dir,
        output done, timeout, entry_denied, exit_denied, fsm_state
    );
endinterface

// File: rtl/parking_gate_occupancy.sv
// Parking lot occupancy counter with an entry/exit gate FSM. A car is counted only
// once the gate sensor confirms its passage. Unused openings close on a timer.
module parking_gate_occupancy #(
    parameter int CAPACITY     = 8,
    parameter int CNT_W        = 4,
    parameter int GATE_TIMEOUT = 16,
    parameter int TMR_W        = 5
) (
    input logic                    clk,
    input logic                    rst_n,
    parking_gate_occupancy_if.slave bus
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] ENTRY_OPEN = 2'd1;
    localparam logic [1:0] EXIT_OPEN  = 2'd2;

    localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_TIMEOUT - 1);

    logic [1:0]       state_q, state_nxt;
    logic [CNT_W-1:0] parked_q, parked_nxt;
    logic [TMR_W-1:0] timer_q, timer_nxt;
    logic             gate_open_q, gate_open_nxt;
    logic             gate_dir_q, gate_dir_nxt;
    logic             done_q, done_nxt;
    logic             timeout_q, timeout_nxt;
    logic             entry_denied_q, entry_denied_nxt;
    logic             exit_denied_q, exit_denied_nxt;
    logic             lot_full;
    logic             lot_vacant;

    assign lot_full   = (parked_q == CAP_C);
    assign lot_vacant = (parked_q == '0);

    always_comb begin
        state_nxt        = state_q;
        parked_nxt       = parked_q;
        timer_nxt        = timer_q;
        gate_open_nxt    = gate_open_q;
        gate_dir_nxt     = gate_dir_q;
        done_nxt         = 1'b0;
        timeout_nxt      = 1'b0;
        entry_denied_nxt = 1'b0;
        exit_denied_nxt  = 1'b0;

        case (state_q)
            IDLE: begin
                // Exit wins a tie: it frees a space, so it can never be refused by a full lot.
                if (bus.exit_req) begin
                    if (!lot_vacant) begin
                        state_nxt     = EXIT_OPEN;
                        timer_nxt     = '0;
                        gate_open_nxt = 1'b1;
                        gate_dir_nxt  = 1'b0;
                    end else begin
                        exit_denied_nxt = 1'b1;
                    end
                end else if (bus.entry_req) begin
                    if (!lot_full) begin
                        state_nxt     = ENTRY_OPEN;
                        timer_nxt     = '0;
                        gate_open_nxt = 1'b1;
                        gate_dir_nxt  = 1'b1;
                    end else begin
                        entry_denied_nxt = 1'b1;
                    end
                end
            end

            ENTRY_OPEN, EXIT_OPEN: begin
                // A passage on the last timer cycle still counts; the sensor outranks expiry.
                if (bus.car_passed) begin
                    if (state_q == ENTRY_OPEN) begin
                        parked_nxt = parked_q + CNT_W'(1);
                    end else begin
                        parked_nxt = parked_q - CNT_W'(1);
                    end
                    done_nxt      = 1'b1;
                    state_nxt     = IDLE;
                    gate_open_nxt = 1'b0;
                end else if (timer_q == TMR_LAST) begin
                    timeout_nxt   = 1'b1;
                    state_nxt     = IDLE;
                    gate_open_nxt = 1'b0;
                end else begin
                    timer_nxt = timer_q + TMR_W'(1);
                end
            end

            default: begin
                state_nxt     = IDLE;
                gate_open_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            parked_q       <= '0;
            timer_q        <= '0;
            gate_open_q    <= 1'b0;
            gate_dir_q     <= 1'b0;
            done_q         <= 1'b0;
            timeout_q      <= 1'b0;
            entry_denied_q <= 1'b0;
            exit_denied_q  <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            parked_q       <= parked_nxt;
            timer_q        <= timer_nxt;
            gate_open_q    <= gate_open_nxt;
            gate_dir_q     <= gate_dir_nxt;
            done_q         <= done_nxt;
            timeout_q      <= timeout_nxt;
            entry_denied_q <= entry_denied_nxt;
            exit_denied_q  <= exit_denied_nxt;
        end
    end

    assign bus.parked       = parked_q;
    assign bus.empty        = CAP_C - parked_q;
    assign bus.full         = lot_full;
    assign bus.vacant       = lot_vacant;
    assign bus.gate_open    = gate_open_q;
    assign bus.gate_dir     = gate_dir_q;
    assign bus.done         = done_q;
    assign bus.timeout      = timeout_q;
    assign bus.entry_denied = entry_denied_q;
    assign bus.exit_denied  = exit_denied_q;
    assign bus.fsm_state    = state_q;
endmodule

// File: tb/tb_parking_gate_occupancy.sv
// Bench for parking_gate_occupancy: directed scenarios then random traffic, all checked
// against a car-queue reference model of the lot.
module tb_parking_gate_occupancy;
    localparam int CAPACITY     = 8;
    localparam int CNT_W        = 4;
    localparam int GATE_TIMEOUT = 16;
    localparam int TMR_W        = 5;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    parking_gate_occupancy_if #(.CNT_W(CNT_W)) bus ();

    parking_gate_occupancy #(
        .CAPACITY(CAPACITY), .CNT_W(CNT_W), .GATE_TIMEOUT(GATE_TIMEOUT), .TMR_W(TMR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: the lot is a queue of car ids; the gate is open since a given cycle
    logic [7:0] exp_q[$];
    int         next_id;
    int         cyc;
    int         opened_at;
    bit         m_open;
    bit         m_dir;
    bit         m_done, m_timeout, m_entry_denied, m_exit_denied;

    task automatic model_reset();
        exp_q.delete();
        m_open = 0; m_dir = 0;
        m_done = 0; m_timeout = 0; m_entry_denied = 0; m_exit_denied = 0;
    endtask

    task automatic model_edge(input bit e, input bit x, input bit p);
        m_done = 0; m_timeout = 0; m_entry_denied = 0; m_exit_denied = 0;
        if (m_open) begin
            if (p) begin
                if (m_dir) begin
                    exp_q.push_back(8'(next_id));
                    next_id++;
                end else begin
                    void'(exp_q.pop_front());
                end
                m_done = 1;
                m_open = 0;
            end else if (cyc - opened_at == GATE_TIMEOUT) begin
                m_timeout = 1;
                m_open = 0;
            end
        end else if (x) begin
            if (exp_q.size() > 0) begin
                m_open = 1; m_dir = 0; opened_at = cyc;
            end else begin
                m_exit_denied = 1;
            end
        end else if (e) begin
            if (exp_q.size() < CAPACITY) begin
                m_open = 1; m_dir = 1; opened_at = cyc;
            end else begin
                m_entry_denied = 1;
            end
        end
        cyc++;
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("parked", 32'(bus.parked), 32'(exp_q.size()));
        check("empty", 32'(bus.empty), 32'(CAPACITY - exp_q.size()));
        check("sum", 32'(bus.parked) + 32'(bus.empty), 32'(CAPACITY));
        check("full", 32'(bus.full), 32'(exp_q.size() == CAPACITY));
        check("vacant", 32'(bus.vacant), 32'(exp_q.size() == 0));
        check("gate_open", 32'(bus.gate_open), 32'(m_open));
        if (m_open) check("gate_dir", 32'(bus.gate_dir), 32'(m_dir));
        check("done", 32'(bus.done), 32'(m_done));
        check("timeout", 32'(bus.timeout), 32'(m_timeout));
        check("entry_denied", 32'(bus.entry_denied), 32'(m_entry_denied));
        check("exit_denied", 32'(bus.exit_denied), 32'(m_exit_denied));
    endtask

    // driver: inputs change #1 after an edge, outputs are sampled #1 after the next edge
    task automatic cycle(input bit e, input bit x, input bit p);
        bus.entry_req  = e;
        bus.exit_req   = x;
        bus.car_passed = p;
        @(posedge clk);
        model_edge(e, x, p);
        #1;
        check_all();
    endtask

    initial begin
        int open_cnt;
        int to_cnt;
        total = 0; bad = 0; next_id = 0; cyc = 0; opened_at = 0;
        bus.entry_req = 0; bus.exit_req = 0; bus.car_passed = 0;
        model_reset();
        rst_n = 0;
        #12;
        check_all();
        check("reset_gate_dir", 32'(bus.gate_dir), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;

        // exit on an empty lot is refused, then re-pulses while held
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 0, 0);

        // fill the lot
        for (int i = 0; i < CAPACITY; i++) begin
            cycle(1, 0, 0);
            cycle(0, 0, 1);
            cycle(0, 0, 0);
        end
        check("filled_parked", 32'(bus.parked), 32'(CAPACITY));
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);

        // tie goes to the exit gate
        cycle(1, 1, 0);
        check("tie_dir", 32'(bus.gate_dir), 32'd0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);

        // unused opening: gate held for exactly GATE_TIMEOUT cycles
        cycle(1, 0, 0);
        open_cnt = int'(bus.gate_open);
        to_cnt = 0;
        for (int i = 0; i < GATE_TIMEOUT + 4; i++) begin
            cycle(0, 0, 0);
            open_cnt += int'(bus.gate_open);
            to_cnt += int'(bus.timeout);
        end
        check("open_cycles", 32'(open_cnt), 32'(GATE_TIMEOUT));
        check("timeout_count", 32'(to_cnt), 32'd1);

        // passage on the final timer cycle counts and suppresses timeout
        cycle(1, 0, 0);
        for (int i = 0; i < GATE_TIMEOUT - 1; i++) cycle(0, 0, 0);
        cycle(0, 0, 1);
        check("last_cycle_done", 32'(bus.done), 32'd1);
        check("last_cycle_timeout", 32'(bus.timeout), 32'd0);
        cycle(0, 0, 0);

        // ignored inputs: sensor while closed, entry request during an exit opening
        cycle(0, 0, 1);
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 1);
        cycle(1, 0, 0);
        check("served_after_idle", 32'(bus.gate_dir), 32'd1);
        cycle(0, 0, 1);
        cycle(0, 0, 0);

        // asynchronous reset in the middle of an entry opening
        cycle(0, 1, 0);
        cycle(0, 0, 1);
        cycle(1, 0, 0);
        bus.entry_req = 0;
        rst_n = 0;
        #1;
        check("async_gate_open", 32'(bus.gate_open), 32'd0);
        check("async_parked", 32'(bus.parked), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        check_all();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 9) < 5), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/parking_gate_occupancy.md
Name: parking_gate_occupancy

Overview:
Sequential successor to the combinational free-spot counter. Tracks lot occupancy up to a parametrised CAPACITY and runs the entry/exit gate handshake. A car is counted only when the gate sensor confirms it has passed. Sits between the gate request logic and the lot display/status path, and drives parked/empty counts directly.

Parameters:
CAPACITY, 8, number of spaces in the lot (>=1)
CNT_W, 4, width of parked/empty counts; must satisfy 2**CNT_W > CAPACITY
GATE_TIMEOUT, 16, cycles the gate stays open waiting for car_passed (>=2)
TMR_W, 5, timer width; must satisfy 2**TMR_W > GATE_TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
entry_req  in  1  car at entry gate, level, sampled in IDLE only
exit_req  in  1  car at exit gate, level, sampled in IDLE only
car_passed  in  1  gate sensor, one-cycle pulse, honoured only while gate open
parked  out  CNT_W  occupied spaces, registered
empty  out  CNT_W  CAPACITY - parked
full  out  1  parked == CAPACITY
vacant  out  1  parked == 0
gate_open  out  1  gate raised, registered
gate_dir  out  1  1 = entry gate, 0 = exit gate; valid while gate_open
done  out  1  one-cycle pulse: passage counted
timeout  out  1  one-cycle pulse: gate closed with no passage
entry_denied  out  1  one-cycle pulse: entry_req while full
exit_denied  out  1  one-cycle pulse: exit_req while vacant

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE, parked=0, empty=CAPACITY, full=0, vacant=1, timer=0, gate_open=0, gate_dir=0. All pulse outputs are 0.
- Reset mid-operation: the gate closes immediately. Any passage in progress is discarded and not counted.
- Invariant: parked+empty == CAPACITY on every cycle.
- empty, full and vacant are combinational from the parked register. There is no extra latency.
- States: IDLE, ENTRY_OPEN, EXIT_OPEN.
- IDLE, exit_req=1 has priority over entry_req because an exit frees a space:
  - parked>0: go to EXIT_OPEN and clear the timer.
  - parked==0: pulse exit_denied and stay in IDLE.
- IDLE, entry_req=1 with exit_req=0:
  - parked<CAPACITY: go to ENTRY_OPEN and clear the timer.
  - full: pulse entry_denied and stay in IDLE.
- IDLE, car_passed: ignored.
- Request latency: a request sampled at edge N gives gate_open=1 and the correct gate_dir from edge N onward.
- Denied pulses are high for exactly the cycle after edge N. A request held high re-pulses every cycle while the condition persists.
- ENTRY_OPEN / EXIT_OPEN: gate_open=1. The timer increments every cycle.
  - car_passed=1: parked +1 (entry) or -1 (exit) at that edge, pulse done, return to IDLE, gate_open=0.
  - Timer reaches GATE_TIMEOUT-1 with no car_passed: pulse timeout, return to IDLE, parked unchanged.
  - car_passed and timer expiry in the same cycle: car_passed wins. done pulses; timeout does not.
  - entry_req/exit_req while the gate is open are ignored and not queued. They are re-evaluated in IDLE.
- Maximum open duration: GATE_TIMEOUT cycles.
- At least one IDLE cycle separates consecutive gate openings.
- Bounds: overflow and underflow are impossible by construction. Requests are gated by full/vacant, and only one passage is counted per opening.
- parked never wraps. Reaching CAPACITY sets full in the same cycle parked updates.

Test Plan:
- Reset: assert rst_n=0 mid-ENTRY_OPEN -> gate_open=0 asynchronously; parked=0, empty=8, vacant=1 after release.
- Fill lot: 8 entry_req/car_passed sequences (CAPACITY=8) -> parked steps 1..8, done pulses each time, full=1 and empty=0 after the 8th. A 9th entry_req -> entry_denied pulse, gate stays closed.
- Exit on empty: exit_req at reset state -> exit_denied pulse 1 cycle later, parked=0, no gate_open.
- Timeout: entry_req, no car_passed -> gate_open high exactly 16 cycles, timeout pulses once, parked unchanged.
- Simultaneous: with parked=8, entry_req=exit_req=1 -> EXIT_OPEN, gate_dir=0; car_passed -> parked=7. car_passed on the final timer cycle -> done=1, timeout=0.
- Ignored inputs: car_passed in IDLE and entry_req during EXIT_OPEN -> no count change. The request is served only after returning to IDLE.
